// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: FSM state encoding,
// prefix byte constants and the odd-parity helper.
package ps2_scancode_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // True when the data byte plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par);
        return ^{data_byte, par};
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Pin and key-event bundle for ps2_scancode_rx; slave = receiver side,
// master = the pins' driver and the downstream keyboard register.
interface ps2_scancode_rx_if;
    import ps2_scancode_rx_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  ps2_clk, ps2_data,
        output scan_code, code_valid, is_break, is_extended,
               parity_err, frame_err, busy
    );

    modport master (
        output ps2_clk, ps2_data,
        input  scan_code, code_valid, is_break, is_extended,
               parity_err, frame_err, busy
    );

endinterface

// File: rtl/ps2_scancode_rx_clk_filter.sv
// ps2_clk synchronizer plus FILTER_LEN-sample glitch filter; fe is a
// one-cycle strobe on each filtered 1->0 transition.
module ps2_scancode_rx_clk_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    output logic filt_clk,
    output logic fe
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [CW-1:0]          run_cnt;
    logic                   clk_s;

    assign clk_s = clk_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '1;
            run_cnt  <= '0;
            filt_clk <= 1'b1;
            fe       <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            fe       <= 1'b0;
            // run_cnt counts consecutive samples disagreeing with filt_clk
            if (clk_s != filt_clk) begin
                if (run_cnt == CW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s;
                    run_cnt  <= '0;
                    fe       <= ~clk_s;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames, checks odd parity/stop, folds E0/F0 prefixes
// into flags. Optional mid-frame abort under macro PS2_TIMEOUT_EN.
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_scancode_rx_if.slave   bus
);

    logic [SYNC_STAGES-1:0] data_sync;
    logic                   data_s;
    logic                   filt_clk;
    logic                   fe;
    logic                   sample;
    ps2_state_e             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic                   ext_flag;
    logic                   brk_flag;

    ps2_scancode_rx_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (bus.ps2_clk),
        .filt_clk (filt_clk),
        .fe       (fe)
    );

    assign data_s = data_sync[SYNC_STAGES-1];
    // fe and the low filt_clk are set on the same edge, so this equals fe
    assign sample = fe & ~filt_clk;
    assign bus.busy = (state != IDLE);

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync       <= '1;
            state           <= IDLE;
            bit_cnt         <= '0;
            shreg           <= '0;
            par_bit         <= 1'b0;
            ext_flag        <= 1'b0;
            brk_flag        <= 1'b0;
            bus.scan_code   <= '0;
            bus.code_valid  <= 1'b0;
            bus.is_break    <= 1'b0;
            bus.is_extended <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.frame_err   <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            data_sync      <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
            bus.code_valid <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;

            if (sample) begin
                unique case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!data_s) begin
                            bus.frame_err <= 1'b1;
                        end else if (!odd_parity_ok(shreg, par_bit)) begin
                            bus.parity_err <= 1'b1;
                            ext_flag       <= 1'b0;
                            brk_flag       <= 1'b0;
                        end else if (shreg == PS2_PREFIX_EXT) begin
                            ext_flag <= 1'b1;
                        end else if (shreg == PS2_PREFIX_BRK) begin
                            brk_flag <= 1'b1;
                        end else begin
                            bus.scan_code   <= shreg;
                            bus.is_break    <= brk_flag;
                            bus.is_extended <= ext_flag;
                            bus.code_valid  <= 1'b1;
                            ext_flag        <= 1'b0;
                            brk_flag        <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

`ifdef PS2_TIMEOUT_EN
            // Abort only fires on non-sample cycles, so it never races the case above
            if (sample || state == IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                to_cnt        <= '0;
                state         <= IDLE;
                bus.frame_err <= 1'b1;
                ext_flag      <= 1'b0;
                brk_flag      <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: hand-built PS/2 frames, pulse counting
// on the falling clk edge, expected values written out per test.
module tb_ps2_scancode_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_scancode_rx_if bus();

    ps2_scancode_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (20000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned cv_cnt = 0, pe_cnt = 0, fe_cnt = 0, multi_cnt = 0;
    int unsigned cv_cyc = 0, stop_fall_cyc = 0;
    int unsigned cv0, pe0, fe0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.code_valid) begin
            cv_cnt++;
            cv_cyc = cyc;
        end
        if (bus.parity_err) pe_cnt++;
        if (bus.frame_err)  fe_cnt++;
        if (int'(bus.code_valid) + int'(bus.parity_err) + int'(bus.frame_err) > 1)
            multi_cnt++;
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        cv0 = cv_cnt;
        pe0 = pe_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        repeat (15) @(negedge clk);
        bus.ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        repeat (20) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_ok ? ~^b : ^b);
        ps2_bit(stop);
        @(negedge clk);
        bus.ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_pulses(input string tag, input int unsigned cv,
                                input int unsigned pe, input int unsigned fr);
        check({tag, "_cv"}, cv_cnt - cv0, cv);
        check({tag, "_pe"}, pe_cnt - pe0, pe);
        check({tag, "_fe"}, fe_cnt - fe0, fr);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_scan_code", 32'(bus.scan_code), 0);
        check("rst_code_valid", 32'(bus.code_valid), 0);
        check("rst_flags", 32'({bus.is_break, bus.is_extended}), 0);
        check("rst_errs", 32'({bus.parity_err, bus.frame_err}), 0);
        check("rst_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Plain make code 1C
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check_pulses("mk1c", 1, 0, 0);
        check("mk1c_code", 32'(bus.scan_code), 32'h1C);
        check("mk1c_brk", 32'(bus.is_break), 0);
        check("mk1c_ext", 32'(bus.is_extended), 0);
        check("mk1c_latency", cv_cyc - stop_fall_cyc, 7);

        // Break: F0 1C, then a following 1C is a make again
        snap();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        check_pulses("brk1c", 1, 0, 0);
        check("brk1c_code", 32'(bus.scan_code), 32'h1C);
        check("brk1c_brk", 32'(bus.is_break), 1);
        send_frame(8'h1C, 1'b1, 1'b1);
        check("mk1c_again_brk", 32'(bus.is_break), 0);

        // Extended break: E0 F0 74
        snap();
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h74, 1'b1, 1'b1);
        check_pulses("ebrk74", 1, 0, 0);
        check("ebrk74_code", 32'(bus.scan_code), 32'h74);
        check("ebrk74_flags", 32'({bus.is_extended, bus.is_break}), 32'b11);

        // Parity error, outputs hold, then clean 29
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check_pulses("par1c", 0, 1, 0);
        check("par1c_hold_code", 32'(bus.scan_code), 32'h74);
        snap();
        send_frame(8'h29, 1'b1, 1'b1);
        check_pulses("mk29", 1, 0, 0);
        check("mk29_code", 32'(bus.scan_code), 32'h29);
        check("mk29_flags", 32'({bus.is_extended, bus.is_break}), 0);

        // Two short clock glitches with data low must not start a frame
        @(negedge clk);
        bus.ps2_data = 1'b0;
        repeat (2) begin
            repeat (10) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        repeat (10) @(negedge clk);
        check("glitch_busy", 32'(bus.busy), 0);
        bus.ps2_data = 1'b1;
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check_pulses("glitch1c", 1, 0, 0);
        check("glitch1c_code", 32'(bus.scan_code), 32'h1C);

        // Bad stop bit; the break prefix survives a framing error
        snap();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b0);
        check_pulses("stop0", 0, 0, 1);
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check_pulses("post_stop0", 1, 0, 0);
        check("post_stop0_brk", 32'(bus.is_break), 1);

        // Reset after five bits discards the frame silently
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        check("midrst_busy_before", 32'(bus.busy), 1);
        snap();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_busy_after", 32'(bus.busy), 0);
        check_pulses("midrst", 0, 0, 0);
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check_pulses("midrst1c", 1, 0, 0);
        check("midrst1c_code", 32'(bus.scan_code), 32'h1C);

`ifdef PS2_TIMEOUT_EN
        // Stalled frame aborts after the idle budget
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        snap();
        repeat (20100) @(negedge clk);
        check_pulses("tmo", 0, 0, 1);
        check("tmo_busy", 32'(bus.busy), 0);
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check_pulses("tmo1c", 1, 0, 0);
        check("tmo1c_code", 32'(bus.scan_code), 32'h1C);
`endif

        check("pulse_overlap", multi_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
